spi_sram_responder: RTL and testbench

Synthesizable responder-side model of a 23LC1024-class serial SRAM, the far end of the SPI/SQI link driven by `spi_sram_encoder`. It decodes command, address and data frames on the SIO pins in the `clk` domain and serves sequential-mode reads and writes from an internal byte array. Used on FPGA builds and in self-contained benches in place of the external SRAM chip.

---
 rtl/spi_sram_pkg.sv | 22 ++
 rtl/spi_sram_sync_edge.sv | 47 ++++
 rtl/spi_sram_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_sram_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared definitions for the serial SRAM link: opcodes, the responder state
// encoding and the on-wire address width.
package spi_sram_pkg;

    localparam int SRAM_ADDR_BITS = 24;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_EQIO  = 8'h38;
    localparam logic [7:0] OP_RSTIO = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } sram_state_e;

endpackage

// File: rtl/spi_sram_sync_edge.sv
// N-stage input synchronizer with single-cycle rise/fall strobes measured
// against the previous synchronized value.
module spi_sram_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic sync_q;
    logic prev_reg;

    generate
        if (STAGES == 0) begin : g_bypass
            assign sync_q = d;
        end else begin : g_chain
            logic [STAGES-1:0] stage_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg <= {STAGES{RESET_VAL}};
                end else begin
                    stage_reg[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end
            assign sync_q = stage_reg[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= RESET_VAL;
        end else begin
            prev_reg <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_reg;
    assign fall = ~sync_q & prev_reg;

endmodule

// File: rtl/spi_sram_responder.sv
// Responder-side model of a 23LC1024-class serial SRAM: decodes SPI/SQI
// frames oversampled in the clk domain and serves sequential reads/writes.
module spi_sram_responder
    import spi_sram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 17,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sram_cs_n,
    input  logic sram_sck,
    input  logic sram_sio0_i,
    input  logic sram_sio1_i,
    input  logic sram_sio2_i,
    input  logic sram_sio3_i,
    output logic sram_sio0_o,
    output logic sram_sio1_o,
    output logic sram_sio2_o,
    output logic sram_sio3_o,
    output logic sram_sio_oe,
    output logic quad_mode,
    output logic busy
);

    logic cs_rise, cs_fall, sck_rise, sck_fall;
    logic [3:0] sio_pins, sio_sync;

    assign sio_pins = {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};

    spi_sram_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .d(sram_cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sram_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .reset(reset), .d(sram_sck), .rise(sck_rise), .fall(sck_fall)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sio
            if (SYNC_STAGES == 0) begin : g_direct
                assign sio_sync[gi] = sio_pins[gi];
            end else begin : g_sync
                logic [SYNC_STAGES-1:0] chain_reg;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        chain_reg <= '0;
                    end else begin
                        chain_reg[0] <= sio_pins[gi];
                        for (int i = 1; i < SYNC_STAGES; i++) begin
                            chain_reg[i] <= chain_reg[i-1];
                        end
                    end
                end
                assign sio_sync[gi] = chain_reg[SYNC_STAGES-1];
            end
        end
    endgenerate

    sram_state_e               state_reg, state_next;
    logic [4:0]                cnt_reg, cnt_next, cnt_inc;
    logic [23:0]               sr_reg, sr_next, shifted;
    logic                      quad_reg, quad_next;
    logic                      is_read_reg, is_read_next;
    logic                      oe_reg, oe_next;
    logic [3:0]                sio_out_reg, sio_out_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [MEM_ADDR_WIDTH-1:0] waddr_reg, waddr_next;
    logic [MEM_ADDR_WIDTH-1:0] fetch_addr;
    logic [7:0]                wdata_reg, wdata_next;
    logic                      we_reg, we_next;
    logic                      fetch;
    logic [7:0]                rd_data_reg;
    logic [7:0]                mem [0:(1<<MEM_ADDR_WIDTH)-1];

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        sr_next      = sr_reg;
        quad_next    = quad_reg;
        is_read_next = is_read_reg;
        oe_next      = oe_reg;
        sio_out_next = sio_out_reg;
        addr_next    = addr_reg;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
        we_next      = 1'b0;
        fetch        = 1'b0;
        fetch_addr   = addr_reg;
        shifted      = quad_reg ? {sr_reg[19:0], sio_sync} : {sr_reg[22:0], sio_sync[0]};
        cnt_inc      = cnt_reg + (quad_reg ? 5'd4 : 5'd1);

        // CS release outranks any SCK edge seen in the same cycle
        if (cs_rise) begin
            state_next   = ST_IDLE;
            oe_next      = 1'b0;
            sio_out_next = 4'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_next = ST_CMD;
                        cnt_next   = 5'd0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        sr_next  = shifted;
                        cnt_next = cnt_inc;
                        if (cnt_inc == 5'd8) begin
                            cnt_next   = 5'd0;
                            state_next = ST_IGNORE;
                            case (shifted[7:0])
                                OP_READ: begin
                                    state_next   = ST_ADDR;
                                    is_read_next = 1'b1;
                                end
                                OP_WRITE: begin
                                    state_next   = ST_ADDR;
                                    is_read_next = 1'b0;
                                end
                                OP_EQIO:  if (!quad_reg) quad_next = 1'b1;
                                OP_RSTIO: if (quad_reg)  quad_next = 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        sr_next  = shifted;
                        cnt_next = cnt_inc;
                        if (cnt_inc == 5'(SRAM_ADDR_BITS)) begin
                            cnt_next  = 5'd0;
                            addr_next = shifted[MEM_ADDR_WIDTH-1:0];
                            if (!is_read_reg) begin
                                state_next = ST_WDATA;
                            end else if (quad_reg) begin
                                state_next = ST_DUMMY;
                            end else begin
                                state_next = ST_RDATA;
                                fetch      = 1'b1;
                                fetch_addr = shifted[MEM_ADDR_WIDTH-1:0];
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == 5'd8) begin
                            cnt_next   = 5'd0;
                            state_next = ST_RDATA;
                            fetch      = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    // cnt_reg counts bits already clocked out of the current byte
                    if (sck_rise) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == 5'd8) begin
                            cnt_next   = 5'd0;
                            addr_next  = addr_reg + MEM_ADDR_WIDTH'(1);
                            fetch      = 1'b1;
                            fetch_addr = addr_reg + MEM_ADDR_WIDTH'(1);
                        end
                    end else if (sck_fall) begin
                        oe_next = 1'b1;
                        if (quad_reg) begin
                            sio_out_next = (cnt_reg == 5'd0) ? rd_data_reg[7:4] : rd_data_reg[3:0];
                        end else begin
                            sio_out_next = {2'b00, rd_data_reg[3'd7 - cnt_reg[2:0]], 1'b0};
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        sr_next  = shifted;
                        cnt_next = cnt_inc;
                        if (cnt_inc == 5'd8) begin
                            cnt_next   = 5'd0;
                            we_next    = 1'b1;
                            waddr_next = addr_reg;
                            wdata_next = shifted[7:0];
                            addr_next  = addr_reg + MEM_ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 5'd0;
            sr_reg      <= 24'd0;
            quad_reg    <= 1'b0;
            is_read_reg <= 1'b0;
            oe_reg      <= 1'b0;
            sio_out_reg <= 4'h0;
            addr_reg    <= '0;
            waddr_reg   <= '0;
            wdata_reg   <= 8'h00;
            we_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            sr_reg      <= sr_next;
            quad_reg    <= quad_next;
            is_read_reg <= is_read_next;
            oe_reg      <= oe_next;
            sio_out_reg <= sio_out_next;
            addr_reg    <= addr_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
            we_reg      <= we_next;
        end
    end

    // Array contents survive reset; only the write strobe is gated by it
    always_ff @(posedge clk) begin
        if (we_reg && !reset) begin
            mem[waddr_reg] <= wdata_reg;
        end
        if (fetch) begin
            rd_data_reg <= mem[fetch_addr];
        end
    end

    assign {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o} = sio_out_reg;
    assign sram_sio_oe = oe_reg;
    assign quad_mode   = quad_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: bit-bangs SPI/SQI frames with
// SCK half-periods of HALF clk cycles and checks hand-computed results.
module tb_spi_sram_responder;

    localparam int HALF = 5;

    logic       clk;
    logic       reset;
    logic       cs_n;
    logic       sck;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic       oe;
    logic       quad;
    logic       busy;

    int   vectors;
    int   miscompares;
    bit   tb_quad;
    logic oe_any, oe_all;
    logic hdr_oe, data_oe;

    spi_sram_responder #(.MEM_ADDR_WIDTH(17), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .sram_cs_n(cs_n),
        .sram_sck(sck),
        .sram_sio0_i(sio_in[0]),
        .sram_sio1_i(sio_in[1]),
        .sram_sio2_i(sio_in[2]),
        .sram_sio3_i(sio_in[3]),
        .sram_sio0_o(sio_out[0]),
        .sram_sio1_o(sio_out[1]),
        .sram_sio2_o(sio_out[2]),
        .sram_sio3_o(sio_out[3]),
        .sram_sio_oe(oe),
        .quad_mode(quad),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One SCK period: drive inputs, capture outputs at the end of the low phase.
    task automatic sck_cycle(input logic [3:0] din, output logic [3:0] dout);
        sio_in = din;
        repeat (HALF) @(negedge clk);
        dout   = sio_out;
        oe_any = oe_any | oe;
        oe_all = oe_all & oe;
        sck    = 1'b1;
        repeat (HALF) @(negedge clk);
        sck    = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic [3:0] d;
        rx = 8'h00;
        if (tb_quad) begin
            sck_cycle(tx[7:4], d);
            rx[7:4] = d;
            sck_cycle(tx[3:0], d);
            rx[3:0] = d;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                sck_cycle({3'b000, tx[i]}, d);
                rx[i] = d[1];
            end
        end
    endtask

    task automatic begin_xfer();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        oe_any = 1'b0;
        oe_all = 1'b1;
    endtask

    task automatic end_xfer();
        repeat (HALF) @(negedge clk);
        cs_n   = 1'b1;
        sio_in = 4'h0;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] rx;
        xfer_byte(op, rx);
        xfer_byte(addr[23:16], rx);
        xfer_byte(addr[15:8], rx);
        xfer_byte(addr[7:0], rx);
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [15:0] data, input int nbytes);
        logic [7:0] rx;
        begin_xfer();
        send_hdr(8'h02, addr);
        if (nbytes == 2) xfer_byte(data[15:8], rx);
        xfer_byte(data[7:0], rx);
        end_xfer();
        $display("write %s addr=%06h data=%04h bytes=%0d", tb_quad ? "sqi" : "spi", addr, data, nbytes);
    endtask

    task automatic do_read(input logic [23:0] addr, input int nbytes, output logic [15:0] data);
        logic [7:0] rx;
        data = 16'h0000;
        begin_xfer();
        send_hdr(8'h03, addr);
        if (tb_quad) xfer_byte(8'h00, rx);
        hdr_oe = oe_any;
        oe_all = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            xfer_byte(8'h00, rx);
            data = {data[7:0], rx};
        end
        data_oe = oe_all;
        end_xfer();
        $display("read  %s addr=%06h data=%04h bytes=%0d", tb_quad ? "sqi" : "spi", addr, data, nbytes);
    endtask

    task automatic send_cmd_only(input logic [7:0] op);
        logic [7:0] rx;
        begin_xfer();
        xfer_byte(op, rx);
        end_xfer();
        $display("cmd   %s op=%02h", tb_quad ? "sqi" : "spi", op);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        cs_n   = 1'b1;
        sck    = 1'b0;
        sio_in = 4'h0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (oe !== 1'b0) begin
            miscompares++; $display("FAIL reset_oe: got %b expected 0", oe);
        end
        vectors++;
        if (sio_out !== 4'h0) begin
            miscompares++; $display("FAIL reset_sio: got %h expected 0", sio_out);
        end
        vectors++;
        if (quad !== 1'b0) begin
            miscompares++; $display("FAIL reset_quad: got %b expected 0", quad);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_spi_rw();
        logic [7:0]  rx;
        logic [15:0] rd;
        tb_quad = 1'b0;
        begin_xfer();
        send_hdr(8'h02, 24'h000100);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL spi_busy: got %b expected 1", busy);
        end
        xfer_byte(8'h5A, rx);
        xfer_byte(8'hC3, rx);
        end_xfer();
        $display("write spi addr=000100 data=5ac3 bytes=2");
        do_read(24'h000100, 2, rd);
        vectors++;
        if (rd !== 16'h5AC3) begin
            miscompares++; $display("FAIL spi_read: got %h expected 5ac3", rd);
        end
        vectors++;
        if (hdr_oe !== 1'b0) begin
            miscompares++; $display("FAIL spi_oe_hdr: got %b expected 0", hdr_oe);
        end
        vectors++;
        if (data_oe !== 1'b1) begin
            miscompares++; $display("FAIL spi_oe_data: got %b expected 1", data_oe);
        end
        vectors++;
        if (oe !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL spi_idle: got oe=%b busy=%b expected 0 0", oe, busy);
        end
    endtask

    task automatic test_mode_switch();
        send_cmd_only(8'hFF);
        vectors++;
        if (quad !== 1'b0) begin
            miscompares++; $display("FAIL spi_rstio_ignored: got %b expected 0", quad);
        end
        send_cmd_only(8'h38);
        vectors++;
        if (quad !== 1'b1) begin
            miscompares++; $display("FAIL eqio: got %b expected 1", quad);
        end
        tb_quad = 1'b1;
    endtask

    task automatic test_quad_rw();
        logic [15:0] rd;
        do_write(24'h000010, 16'hABCD, 2);
        do_read(24'h000010, 2, rd);
        vectors++;
        if (rd !== 16'hABCD) begin
            miscompares++; $display("FAIL quad_read: got %h expected abcd", rd);
        end
        vectors++;
        if (hdr_oe !== 1'b0) begin
            miscompares++; $display("FAIL quad_oe_hdr: got %b expected 0", hdr_oe);
        end
        vectors++;
        if (data_oe !== 1'b1) begin
            miscompares++; $display("FAIL quad_oe_data: got %b expected 1", data_oe);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] rd;
        do_write(24'h01FFFF, 16'h1122, 2);
        do_read(24'h000000, 1, rd);
        vectors++;
        if (rd[7:0] !== 8'h22) begin
            miscompares++; $display("FAIL wrap_low: got %h expected 22", rd[7:0]);
        end
        do_read(24'h01FFFF, 2, rd);
        vectors++;
        if (rd !== 16'h1122) begin
            miscompares++; $display("FAIL wrap_read: got %h expected 1122", rd);
        end
    endtask

    task automatic test_abort();
        logic [7:0]  rx;
        logic [3:0]  d;
        logic [15:0] rd;
        do_write(24'h000200, 16'h0077, 1);
        begin_xfer();
        xfer_byte(8'h02, rx);
        for (int i = 0; i < 3; i++) sck_cycle(4'hF, d);
        end_xfer();
        $display("abort sqi write after 3 address nibbles");
        vectors++;
        if (busy !== 1'b0 || oe !== 1'b0) begin
            miscompares++; $display("FAIL abort_addr: got busy=%b oe=%b expected 0 0", busy, oe);
        end
        begin_xfer();
        send_hdr(8'h02, 24'h000200);
        sck_cycle(4'h9, d);
        end_xfer();
        $display("abort sqi write after 1 data nibble");
        begin_xfer();
        send_hdr(8'h03, 24'h000200);
        xfer_byte(8'h00, rx);
        sck_cycle(4'h0, d);
        vectors++;
        if (oe !== 1'b1) begin
            miscompares++; $display("FAIL abort_read_oe: got %b expected 1", oe);
        end
        end_xfer();
        $display("abort sqi read after 1 data nibble");
        vectors++;
        if (oe !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_read_idle: got oe=%b busy=%b expected 0 0", oe, busy);
        end
        do_read(24'h000200, 1, rd);
        vectors++;
        if (rd[7:0] !== 8'h77) begin
            miscompares++; $display("FAIL abort_data: got %h expected 77", rd[7:0]);
        end
    endtask

    task automatic test_rstio();
        send_cmd_only(8'hFF);
        vectors++;
        if (quad !== 1'b0) begin
            miscompares++; $display("FAIL rstio: got %b expected 0", quad);
        end
        tb_quad = 1'b0;
        send_cmd_only(8'h38);
        vectors++;
        if (quad !== 1'b1) begin
            miscompares++; $display("FAIL eqio_again: got %b expected 1", quad);
        end
        tb_quad = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        logic [7:0]  rx;
        logic [3:0]  d;
        logic [15:0] rd;
        begin_xfer();
        send_hdr(8'h03, 24'h000010);
        xfer_byte(8'h00, rx);
        sck_cycle(4'h0, d);
        sck_cycle(4'h0, d);
        vectors++;
        if (d !== 4'hB || oe !== 1'b1) begin
            miscompares++; $display("FAIL mid_read_nibble: got %h oe=%b expected b oe=1", d, oe);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (oe !== 1'b0 || quad !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mid_read_reset: got oe=%b quad=%b busy=%b expected 0 0 0", oe, quad, busy);
        end
        reset = 1'b0;
        cs_n  = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        $display("reset asserted during sqi read");
        tb_quad = 1'b0;
        do_read(24'h000100, 1, rd);
        vectors++;
        if (rd[7:0] !== 8'h5A) begin
            miscompares++; $display("FAIL post_reset_spi: got %h expected 5a", rd[7:0]);
        end
        do_read(24'h000010, 2, rd);
        vectors++;
        if (rd !== 16'hABCD) begin
            miscompares++; $display("FAIL post_reset_mem: got %h expected abcd", rd);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        tb_quad     = 1'b0;
        oe_any      = 1'b0;
        oe_all      = 1'b1;
        hdr_oe      = 1'b0;
        data_oe     = 1'b0;
        test_reset();
        test_spi_rw();
        test_mode_switch();
        test_quad_rw();
        test_wrap();
        test_abort();
        test_rstio();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
